result_scoreboard: RTL and testbench

- Parametrised end-of-run scoreboard for the pipelined RISC-V / cache test environment.
- Keeps a shadow copy of data memory, updated by snooping D-cache word writes.
- Detects end of program, either when the PC crosses a threshold or when an explicit done pulse arrives.
- After end of program, streams every shadow word against a golden memory over a 1-cycle-latency read port, then reports error count, first mismatch, run duration and timeout/out-of-range flags.

---
 rtl/result_scoreboard_if.sv | 42 ++++
 rtl/result_scoreboard.sv | 142 ++++++++++++++
 tb/tb_result_scoreboard.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_scoreboard_if.sv
// Bus bundle between the end-of-run scoreboard and its environment:
// shadow preload, D-cache snoop, run control, golden read port and results.
interface result_scoreboard_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ERR_W  = 9,
  parameter int unsigned CYC_W  = 16
);
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic              snoop_wen;
  logic [29:0]       snoop_addr;
  logic [DATA_W-1:0] snoop_data;
  logic [31:0]       pc;
  logic              done_req;
  logic              gold_rd;
  logic [ADDR_W-1:0] gold_addr;
  logic [DATA_W-1:0] gold_rdata;
  logic              checking;
  logic              finish;
  logic [ERR_W-1:0]  error_num;
  logic              first_err_valid;
  logic [ADDR_W-1:0] first_err_addr;
  logic [CYC_W-1:0]  duration;
  logic              timeout;
  logic              oob_write;

  modport master (
    output init_we, init_addr, init_data, snoop_wen, snoop_addr, snoop_data,
           pc, done_req, gold_rdata,
    input  gold_rd, gold_addr, checking, finish, error_num, first_err_valid,
           first_err_addr, duration, timeout, oob_write
  );

  modport slave (
    input  init_we, init_addr, init_data, snoop_wen, snoop_addr, snoop_data,
           pc, done_req, gold_rdata,
    output gold_rd, gold_addr, checking, finish, error_num, first_err_valid,
           first_err_addr, duration, timeout, oob_write
  );
endinterface

// File: rtl/result_scoreboard.sv
// End-of-run scoreboard: shadows data memory from D-cache writes, then after
// the run ends streams every shadow word against golden memory and reports.
module result_scoreboard #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned END_PC  = 400,
  parameter int unsigned ERR_W   = 9,
  parameter int unsigned CYC_W   = 16,
  parameter int unsigned TIMEOUT = 1000000
) (
  input logic clk,
  input logic rst,
  result_scoreboard_if.slave bus
);
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned IDLE_W = 32;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DRAIN, S_REPORT, S_END} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shadow [DEPTH];
  logic [DATA_W-1:0] r_shadow_q;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_cmp_addr;
  logic              r_cmp_vld;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [CYC_W-1:0]  r_duration;
  logic [ERR_W-1:0]  r_error_num;
  logic              r_first_vld;
  logic [ADDR_W-1:0] r_first_addr;
  logic              r_gold_rd;
  logic              r_checking;
  logic              r_finish;
  logic              r_timeout;
  logic              r_oob;

  logic w_in_idle;
  logic w_trigger;
  logic w_expire;
  logic w_snoop_ok;
  logic w_snoop_oob;
  logic w_mismatch;

  assign w_in_idle   = (r_state == S_IDLE);
  assign w_trigger   = w_in_idle && ((bus.pc >= 32'(END_PC)) || bus.done_req);
  assign w_expire    = w_in_idle && (TIMEOUT != 0) &&
                       (r_idle_cnt == IDLE_W'(TIMEOUT - 1));
  assign w_snoop_ok  = bus.snoop_wen && (bus.snoop_addr <  30'(DEPTH));
  assign w_snoop_oob = bus.snoop_wen && (bus.snoop_addr >= 30'(DEPTH));
  // Case inequality so an undriven golden word is flagged, not silently passed
  assign w_mismatch  = r_cmp_vld && (bus.gold_rdata !== r_shadow_q);

  // Next-state logic; a trigger takes priority over a coincident timeout
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_trigger)     w_state_nxt = S_CHECK;
        else if (w_expire) w_state_nxt = S_REPORT;
      end
      S_CHECK:  if (r_cnt == '1) w_state_nxt = S_DRAIN;
      S_DRAIN:  w_state_nxt = S_REPORT;
      S_REPORT: w_state_nxt = S_END;
      S_END:    w_state_nxt = S_END;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cmp_addr   <= '0;
      r_cmp_vld    <= 1'b0;
      r_idle_cnt   <= '0;
      r_duration   <= '0;
      r_error_num  <= '0;
      r_first_vld  <= 1'b0;
      r_first_addr <= '0;
      r_gold_rd    <= 1'b0;
      r_checking   <= 1'b0;
      r_finish     <= 1'b0;
      r_timeout    <= 1'b0;
      r_oob        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gold_rd  <= (w_state_nxt == S_CHECK);
      r_checking <= (w_state_nxt == S_CHECK) || (w_state_nxt == S_DRAIN);
      r_finish   <= (w_state_nxt == S_END);
      r_cmp_vld  <= (r_state == S_CHECK);

      if (w_in_idle) begin
        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        r_cnt      <= '0;
        if ((w_state_nxt == S_IDLE) && (r_duration != '1))
          r_duration <= r_duration + CYC_W'(1);
        if (w_snoop_oob)
          r_oob <= 1'b1;
        if (w_expire && !w_trigger)
          r_timeout <= 1'b1;
      end

      if (r_state == S_CHECK) begin
        r_cnt      <= r_cnt + ADDR_W'(1);
        r_cmp_addr <= r_cnt;
      end

      if (w_mismatch) begin
        if (r_error_num != '1)
          r_error_num <= r_error_num + ERR_W'(1);
        if (!r_first_vld) begin
          r_first_vld  <= 1'b1;
          r_first_addr <= r_cmp_addr;
        end
      end
    end
  end

  // Shadow memory survives reset; snoop is applied after preload so it wins a tie
  always_ff @(posedge clk) begin
    if (w_in_idle) begin
      if (bus.init_we)
        r_shadow[bus.init_addr] <= bus.init_data;
      if (w_snoop_ok)
        r_shadow[bus.snoop_addr[ADDR_W-1:0]] <= bus.snoop_data;
    end
    if (r_state == S_CHECK)
      r_shadow_q <= r_shadow[r_cnt];
  end

  assign bus.gold_rd         = r_gold_rd;
  assign bus.gold_addr       = r_cnt;
  assign bus.checking        = r_checking;
  assign bus.finish          = r_finish;
  assign bus.error_num       = r_error_num;
  assign bus.first_err_valid = r_first_vld;
  assign bus.first_err_addr  = r_first_addr;
  assign bus.duration        = r_duration;
  assign bus.timeout         = r_timeout;
  assign bus.oob_write       = r_oob;
endmodule

// File: tb/tb_result_scoreboard.sv
// Randomized bench for result_scoreboard against a whole-memory reference model,
// plus a second instance with a short timeout.
module tb_result_scoreboard;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ERR_W  = 9;
  localparam int unsigned CYC_W  = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned END_PC = 400;
  localparam int unsigned TO_CYC = 64;

  logic clk = 1'b0;
  logic rst;
  logic rst_to;
  always #5 clk = ~clk;

  result_scoreboard_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W), .CYC_W(CYC_W)) bus ();
  result_scoreboard_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W), .CYC_W(CYC_W)) bus_to ();

  result_scoreboard #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .END_PC(END_PC), .ERR_W(ERR_W),
                      .CYC_W(CYC_W), .TIMEOUT(1000000))
    u_dut (.clk(clk), .rst(rst), .bus(bus));

  result_scoreboard #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .END_PC(END_PC), .ERR_W(ERR_W),
                      .CYC_W(CYC_W), .TIMEOUT(TO_CYC))
    u_dut_to (.clk(clk), .rst(rst_to), .bus(bus_to));

  logic [DATA_W-1:0] gold_mem [DEPTH];
  logic [DATA_W-1:0] sh_model [DEPTH];
  bit exp_oob;
  int idle_edges;
  int n_checks = 0;
  int n_fail   = 0;

  // Golden memory with one-cycle read latency
  always @(posedge clk) begin
    if (bus.gold_rd)    bus.gold_rdata    <= gold_mem[bus.gold_addr];
    if (bus_to.gold_rd) bus_to.gold_rdata <= gold_mem[bus_to.gold_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.init_we    = 1'b0;
    bus.init_addr  = '0;
    bus.init_data  = '0;
    bus.snoop_wen  = 1'b0;
    bus.snoop_addr = '0;
    bus.snoop_data = '0;
    bus.done_req   = 1'b0;
    bus.pc         = 32'($urandom_range(END_PC - 1, 0));
  endtask

  task automatic start_run();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_edges = 0;
    exp_oob = 1'b0;
  endtask

  task automatic idle_step();
    @(posedge clk);
    idle_edges++;
    @(negedge clk);
  endtask

  function automatic void model_write(input bit iw, input int ia, input logic [DATA_W-1:0] idat,
                                      input bit sw, input logic [29:0] sa,
                                      input logic [DATA_W-1:0] sdat);
    if (iw) sh_model[ia] = idat;
    if (sw) begin
      if (sa < 30'(DEPTH)) sh_model[int'(sa)] = sdat;
      else exp_oob = 1'b1;
    end
  endfunction

  task automatic wr_cycle(input bit iw, input int ia, input logic [DATA_W-1:0] idat,
                          input bit sw, input logic [29:0] sa, input logic [DATA_W-1:0] sdat);
    bus.init_we    = iw;
    bus.init_addr  = ADDR_W'(ia);
    bus.init_data  = idat;
    bus.snoop_wen  = sw;
    bus.snoop_addr = sa;
    bus.snoop_data = sdat;
    idle_step();
    bus.init_we   = 1'b0;
    bus.snoop_wen = 1'b0;
    model_write(iw, ia, idat, sw, sa, sdat);
  endtask

  function automatic int model_errors(input int last);
    int n = 0;
    for (int i = 0; i <= last; i++)
      if (sh_model[i] !== gold_mem[i]) n++;
    return n;
  endfunction

  // Fire the trigger (optionally with a same-cycle snoop), run to finish, compare with model
  task automatic finish_run(input string tag, input bit use_done, input bit sw,
                            input logic [29:0] sa, input logic [DATA_W-1:0] sdat);
    int edges = 0;
    int gold_cnt = 0;
    int addr_bad = 0;
    int exp_err;
    int exp_first = 0;
    bit exp_fv = 1'b0;
    if (use_done) bus.done_req = 1'b1;
    else          bus.pc = 32'(END_PC + $urandom_range(50, 0));
    bus.snoop_wen  = sw;
    bus.snoop_addr = sa;
    bus.snoop_data = sdat;
    @(posedge clk);
    @(negedge clk);
    model_write(1'b0, 0, '0, sw, sa, sdat);
    bus.done_req  = 1'b0;
    bus.snoop_wen = 1'b0;
    chk({tag, ".checking"}, 64'(bus.checking), 64'd1);
    while (!bus.finish && edges < 400) begin
      if (bus.gold_rd) begin
        if (bus.gold_addr != ADDR_W'(gold_cnt)) addr_bad++;
        gold_cnt++;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    exp_err = model_errors(DEPTH - 1);
    for (int i = DEPTH - 1; i >= 0; i--)
      if (sh_model[i] !== gold_mem[i]) begin exp_fv = 1'b1; exp_first = i; end
    if (exp_err > (1 << ERR_W) - 1) exp_err = (1 << ERR_W) - 1;
    chk({tag, ".finish"},    64'(bus.finish), 64'd1);
    chk({tag, ".latency"},   64'(edges), 64'(DEPTH + 2));
    chk({tag, ".gold_rds"},  64'(gold_cnt), 64'(DEPTH));
    chk({tag, ".gold_seq"},  64'(addr_bad), 64'd0);
    chk({tag, ".errors"},    64'(bus.error_num), 64'(exp_err));
    chk({tag, ".first_vld"}, 64'(bus.first_err_valid), 64'(exp_fv));
    chk({tag, ".first_adr"}, 64'(bus.first_err_addr), 64'(exp_first));
    chk({tag, ".duration"},  64'(bus.duration), 64'(idle_edges));
    chk({tag, ".timeout"},   64'(bus.timeout), 64'd0);
    chk({tag, ".oob"},       64'(bus.oob_write), 64'(exp_oob));
    // Inputs are ignored once the run has ended
    bus.done_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.done_req = 1'b0;
    chk({tag, ".hold_fin"},  64'(bus.finish), 64'd1);
    chk({tag, ".hold_err"},  64'(bus.error_num), 64'(exp_err));
    chk({tag, ".hold_chk"},  64'(bus.checking), 64'd0);
    bus.pc = 32'($urandom_range(END_PC - 1, 0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".gold_rd"},   64'(bus.gold_rd), 64'd0);
    chk({tag, ".checking"},  64'(bus.checking), 64'd0);
    chk({tag, ".finish"},    64'(bus.finish), 64'd0);
    chk({tag, ".errors"},    64'(bus.error_num), 64'd0);
    chk({tag, ".first_vld"}, 64'(bus.first_err_valid), 64'd0);
    chk({tag, ".first_adr"}, 64'(bus.first_err_addr), 64'd0);
    chk({tag, ".duration"},  64'(bus.duration), 64'd0);
    chk({tag, ".timeout"},   64'(bus.timeout), 64'd0);
    chk({tag, ".oob"},       64'(bus.oob_write), 64'd0);
  endtask

  initial begin
    int edges;
    int seen;
    logic [29:0] sa;
    logic [DATA_W-1:0] d;
    rst    = 1'b1;
    rst_to = 1'b1;
    clear_inputs();
    bus_to.init_we    = 1'b0;
    bus_to.init_addr  = '0;
    bus_to.init_data  = '0;
    bus_to.snoop_wen  = 1'b0;
    bus_to.snoop_addr = '0;
    bus_to.snoop_data = '0;
    bus_to.done_req   = 1'b0;
    bus_to.pc         = 32'h10;
    for (int i = 0; i < DEPTH; i++) gold_mem[i] = $urandom;
    #12;
    chk_all_zero("reset");

    // Preload shadow equal to golden, then a clean run triggered at cycle 50
    start_run();
    for (int i = 0; i < DEPTH; i++) wr_cycle(1'b1, i, gold_mem[i], 1'b0, '0, '0);
    start_run();
    repeat (50) idle_step();
    finish_run("clean", 1'b0, 1'b0, '0, '0);

    // Two snooped words that differ from golden
    if (gold_mem[3] == 32'hDEADBEEF)   gold_mem[3]   = 32'h0;
    if (gold_mem[200] == 32'hDEADBEEF) gold_mem[200] = 32'h0;
    start_run();
    wr_cycle(1'b0, 0, '0, 1'b1, 30'd3, 32'hDEADBEEF);
    wr_cycle(1'b0, 0, '0, 1'b1, 30'd200, 32'hDEADBEEF);
    repeat ($urandom_range(20, 1)) idle_step();
    finish_run("snoop2", 1'b0, 1'b0, '0, '0);

    // Out-of-range snoop is dropped and flagged
    start_run();
    wr_cycle(1'b1, 3, gold_mem[3], 1'b0, '0, '0);
    wr_cycle(1'b1, 200, gold_mem[200], 1'b0, '0, '0);
    wr_cycle(1'b0, 0, '0, 1'b1, 30'h100, $urandom);
    finish_run("oob", 1'b1, 1'b0, '0, '0);

    // done_req with a same-cycle snoop write
    start_run();
    repeat (5) idle_step();
    finish_run("done_wr", 1'b1, 1'b1, 30'd7, gold_mem[7] ^ 32'h1);

    // Same-index preload and snoop in one cycle: snoop wins
    start_run();
    wr_cycle(1'b1, 7, gold_mem[7], 1'b1, 30'd7, gold_mem[7]);
    wr_cycle(1'b1, 9, gold_mem[9], 1'b1, 30'd9, ~gold_mem[9]);
    wr_cycle(1'b1, 10, ~gold_mem[10], 1'b1, 30'd11, gold_mem[11]);
    finish_run("tie", 1'b0, 1'b0, '0, '0);

    // Randomized write mixes
    for (int it = 0; it < 4; it++) begin
      start_run();
      repeat ($urandom_range(20, 5)) begin
        sa = ($urandom_range(7, 0) == 0) ? 30'(DEPTH + $urandom_range(5000, 0))
                                         : 30'($urandom_range(DEPTH - 1, 0));
        d  = ($urandom_range(1, 0) == 0) ? gold_mem[int'(sa[ADDR_W-1:0])] : $urandom;
        wr_cycle(1'($urandom_range(1, 0)), int'($urandom_range(DEPTH - 1, 0)), $urandom,
                 1'($urandom_range(1, 0)), sa, d);
      end
      repeat ($urandom_range(10, 0)) idle_step();
      finish_run($sformatf("rand%0d", it), 1'($urandom_range(1, 0)), 1'b0, '0, '0);
    end

    // Reset in the middle of CHECK, then a full retrigger
    start_run();
    wr_cycle(1'b0, 0, '0, 1'b1, 30'd5, ~gold_mem[5]);
    bus.pc = 32'(END_PC);
    @(posedge clk);
    @(negedge clk);
    repeat (100) @(negedge clk);
    chk("midrst.addr", 64'(bus.gold_addr), 64'd100);
    chk("midrst.pre_err", 64'(bus.error_num), 64'(model_errors(98)));
    bus.pc = 32'($urandom_range(END_PC - 1, 0));
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    idle_edges = 0;
    exp_oob = 1'b0;
    repeat (7) idle_step();
    finish_run("retrig", 1'b0, 1'b0, '0, '0);

    // Timeout instance: no trigger ever arrives
    @(negedge clk);
    rst_to = 1'b0;
    edges = 0;
    seen = 0;
    while (!bus_to.finish && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus_to.gold_rd || bus_to.checking) seen++;
    end
    chk("to.latency",  64'(edges), 64'(TO_CYC + 1));
    chk("to.timeout",  64'(bus_to.timeout), 64'd1);
    chk("to.errors",   64'(bus_to.error_num), 64'd0);
    chk("to.gold_rd",  64'(seen), 64'd0);
    chk("to.duration", 64'(bus_to.duration), 64'(TO_CYC - 1));

    // Trigger in the very cycle the idle counter expires
    rst_to = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_to = 1'b0;
    repeat (TO_CYC - 1) @(negedge clk);
    bus_to.done_req = 1'b1;
    @(negedge clk);
    bus_to.done_req = 1'b0;
    chk("tie_to.checking", 64'(bus_to.checking), 64'd1);
    edges = 0;
    while (!bus_to.finish && edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("tie_to.latency",  64'(edges), 64'(DEPTH + 2));
    chk("tie_to.timeout",  64'(bus_to.timeout), 64'd0);
    chk("tie_to.duration", 64'(bus_to.duration), 64'(TO_CYC - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
